// File: rtl/alu_mc.sv
// -----------------------------------------------------------------------------
// alu_mc -- multi-cycle integer ALU with a valid/ready request port and a
// valid/ready result port.
//
// Logic, shift, rotate, add/sub/inc/dec, NOP and unknown opcodes finish on the
// accepting edge. MUL runs a one-bit-per-cycle shift-add over operand
// magnitudes. DIV/MOD run a one-bit-per-cycle restoring divider.
//
// Optional feature: define ALU_MC_DIV_EN to build the iterative divider. When
// it is not defined, DIV and MOD decode as unknown opcodes and div_zero is
// tied low.
//
// Latency is counted in rising clock edges, with the accepting edge as edge 1:
// single-cycle ops present out_valid after edge 1, MUL/DIV/MOD after edge
// WIDTH+1 (one edge to load, WIDTH iteration edges).
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_valid   request valid            in_ready   request can be accepted
//   opcode     5-bit operation code     data_a/b   signed operands
//   out_valid  result valid             out_ready  consumer takes result
//   result     registered result
//   overflow, error, div_zero  registered status flags, qualified by out_valid
//   dbg_state  current FSM state (IDLE=0, EXEC=1, DONE=2)
// -----------------------------------------------------------------------------
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [4:0]       opcode,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             overflow,
  output logic             error,
  output logic             div_zero,
  output logic [1:0]       dbg_state
);

  localparam int LW = $clog2(WIDTH);

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_NOT  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NAND = 5'd5;
  localparam logic [4:0] OP_NOR  = 5'd6;
  localparam logic [4:0] OP_NXOR = 5'd7;
  localparam logic [4:0] OP_LSH  = 5'd8;
  localparam logic [4:0] OP_RSH  = 5'd9;
  localparam logic [4:0] OP_ALSH = 5'd10;
  localparam logic [4:0] OP_ARSH = 5'd11;
  localparam logic [4:0] OP_ROTL = 5'd12;
  localparam logic [4:0] OP_ROTR = 5'd13;
  localparam logic [4:0] OP_INC  = 5'd14;
  localparam logic [4:0] OP_DEC  = 5'd15;
  localparam logic [4:0] OP_ADD  = 5'd16;
  localparam logic [4:0] OP_SUB  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
`ifdef ALU_MC_DIV_EN
  localparam logic [4:0] OP_DIV  = 5'd19;
  localparam logic [4:0] OP_MOD  = 5'd20;
`endif

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Handshakes: a request is taken on a rising edge where in_valid and
  // in_ready are both 1; a result is consumed on a rising edge where out_valid
  // and out_ready are both 1. in_ready and out_valid are registered and never
  // depend combinationally on in_valid or out_ready.

  logic [1:0]         state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic               out_valid_q, out_valid_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               ovf_q, ovf_d;
  logic               err_q, err_d;
  logic [LW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0]   mplier_q, mplier_d;
  logic               neg_q, neg_d;

  // ---------------------------------------------------------------------------
  // Single-cycle datapath, driven straight from the request inputs
  // ---------------------------------------------------------------------------
  logic [LW-1:0]      sh;
  logic               sh_big;
  logic [2*WIDTH-1:0] rotl_w, rotr_w;
  logic [WIDTH-1:0]   sum_add, sum_sub, sum_inc, sum_dec;
  logic [WIDTH-1:0]   s_res;
  logic               s_ovf, s_err;

  assign sh      = data_b[LW-1:0];
  assign sh_big  = |data_b[WIDTH-1:LW];
  // Rotates by shifting a doubled copy; the amount is already modulo WIDTH.
  assign rotl_w  = {data_a, data_a} << sh;
  assign rotr_w  = {data_a, data_a} >> sh;
  assign sum_add = data_a + data_b;
  assign sum_sub = data_a - data_b;
  assign sum_inc = data_a + WIDTH'(1);
  assign sum_dec = data_a - WIDTH'(1);

  always_comb begin
    s_res = '0;
    s_ovf = 1'b0;
    s_err = 1'b0;
    case (opcode)
      OP_NOP:  s_res = result_q;
      OP_NOT:  s_res = ~data_a;
      OP_AND:  s_res = data_a & data_b;
      OP_OR:   s_res = data_a | data_b;
      OP_XOR:  s_res = data_a ^ data_b;
      OP_NAND: s_res = ~(data_a & data_b);
      OP_NOR:  s_res = ~(data_a | data_b);
      OP_NXOR: s_res = ~(data_a ^ data_b);
      OP_LSH, OP_ALSH: s_res = sh_big ? '0 : (data_a << sh);
      OP_RSH:  s_res = sh_big ? '0 : (data_a >> sh);
      OP_ARSH: s_res = sh_big ? {WIDTH{data_a[WIDTH-1]}}
                              : $unsigned($signed(data_a) >>> sh);
      OP_ROTL: s_res = rotl_w[2*WIDTH-1:WIDTH];
      OP_ROTR: s_res = rotr_w[WIDTH-1:0];
      OP_INC: begin
        s_res = sum_inc;
        s_ovf = ~data_a[WIDTH-1] & sum_inc[WIDTH-1];
      end
      OP_DEC: begin
        s_res = sum_dec;
        s_ovf = data_a[WIDTH-1] & ~sum_dec[WIDTH-1];
      end
      OP_ADD: begin
        s_res = sum_add;
        s_ovf = (data_a[WIDTH-1] == data_b[WIDTH-1]) &&
                (sum_add[WIDTH-1] != data_a[WIDTH-1]);
      end
      OP_SUB: begin
        s_res = sum_sub;
        s_ovf = (data_a[WIDTH-1] != data_b[WIDTH-1]) &&
                (sum_sub[WIDTH-1] != data_a[WIDTH-1]);
      end
`ifdef ALU_MC_DIV_EN
      // Only reached with data_b == 0; non-zero divisors take the EXEC path.
      OP_DIV: begin
        s_res = '1;
        s_err = 1'b1;
      end
      OP_MOD: begin
        s_res = data_a;
        s_err = 1'b1;
      end
`endif
      default: s_err = 1'b1;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Iterative datapath. Both MUL and DIV work on operand magnitudes and apply
  // the sign at the end; |most negative| = 2^(WIDTH-1) still fits unsigned.
  // ---------------------------------------------------------------------------
  logic [WIDTH-1:0]   a_mag, b_mag;
  logic [2*WIDTH-1:0] mul_acc_nx, mul_prod;
  logic               start_mul, start_div, cnt_last;

  assign a_mag      = data_a[WIDTH-1] ? -data_a : data_a;
  assign b_mag      = data_b[WIDTH-1] ? -data_b : data_b;
  assign mul_acc_nx = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_prod   = neg_q ? -mul_acc_nx : mul_acc_nx;
  assign start_mul  = (opcode == OP_MUL);
  assign cnt_last   = (cnt_q == LW'(WIDTH - 1));

`ifdef ALU_MC_DIV_EN
  logic             div_zero_q, div_zero_d;
  logic             is_div_q, is_div_d;
  logic             is_mod_q, is_mod_d;
  logic             ovf_pend_q, ovf_pend_d;
  logic [WIDTH:0]   rem_sh, rem_diff;
  logic             q_bit;
  logic [WIDTH-1:0] rem_nx, quo_nx, div_val;

  assign start_div = ((opcode == OP_DIV) || (opcode == OP_MOD)) &&
                     (data_b != '0);
  // Restoring step: the dividend shifts out of mplier_q's top while quotient
  // bits shift into its bottom; acc_q holds the partial remainder and
  // mcand_q the divisor.
  assign rem_sh    = {acc_q[WIDTH-1:0], mplier_q[WIDTH-1]};
  assign rem_diff  = rem_sh - {1'b0, mcand_q[WIDTH-1:0]};
  assign q_bit     = ~rem_diff[WIDTH];
  assign rem_nx    = q_bit ? rem_diff[WIDTH-1:0] : rem_sh[WIDTH-1:0];
  assign quo_nx    = {mplier_q[WIDTH-2:0], q_bit};
  assign div_val   = is_mod_q ? rem_nx : quo_nx;
`else
  assign start_div = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // FSM and register next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d  = state_q;
    result_d = result_q;
    ovf_d    = ovf_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    neg_d    = neg_q;
`ifdef ALU_MC_DIV_EN
    div_zero_d = div_zero_q;
    is_div_d   = is_div_q;
    is_mod_d   = is_mod_q;
    ovf_pend_d = ovf_pend_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid && in_ready_q) begin
          cnt_d = '0;
          acc_d = '0;
          if (start_mul) begin
            state_d  = EXEC;
            mcand_d  = {{WIDTH{1'b0}}, a_mag};
            mplier_d = b_mag;
            neg_d    = data_a[WIDTH-1] ^ data_b[WIDTH-1];
`ifdef ALU_MC_DIV_EN
            is_div_d = 1'b0;
`endif
          end
`ifdef ALU_MC_DIV_EN
          else if (start_div) begin
            state_d    = EXEC;
            is_div_d   = 1'b1;
            is_mod_d   = (opcode == OP_MOD);
            mcand_d    = {{WIDTH{1'b0}}, b_mag};
            mplier_d   = a_mag;
            // Remainder takes the dividend's sign; quotient the sign product.
            neg_d      = (opcode == OP_MOD) ? data_a[WIDTH-1]
                                            : data_a[WIDTH-1] ^ data_b[WIDTH-1];
            // MIN / -1: the magnitude quotient 2^(WIDTH-1) already reads back
            // as MIN, only the flag needs raising.
            ovf_pend_d = (opcode == OP_DIV) &&
                         (data_a == {1'b1, {(WIDTH-1){1'b0}}}) &&
                         (data_b == '1);
          end
`endif
          else begin
            state_d  = DONE;
            result_d = s_res;
            ovf_d    = s_ovf;
            err_d    = s_err;
`ifdef ALU_MC_DIV_EN
            div_zero_d = (opcode == OP_DIV) || (opcode == OP_MOD);
`endif
          end
        end
      end
      EXEC: begin
        cnt_d = cnt_q + LW'(1);
`ifdef ALU_MC_DIV_EN
        if (is_div_q) begin
          acc_d    = {{WIDTH{1'b0}}, rem_nx};
          mplier_d = quo_nx;
          if (cnt_last) begin
            state_d    = DONE;
            result_d   = neg_q ? -div_val : div_val;
            ovf_d      = ovf_pend_q;
            err_d      = 1'b0;
            div_zero_d = 1'b0;
          end
        end else
`endif
        begin
          acc_d    = mul_acc_nx;
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          if (cnt_last) begin
            state_d  = DONE;
            result_d = mul_prod[WIDTH-1:0];
            ovf_d    = mul_prod[2*WIDTH-1:WIDTH] != {WIDTH{mul_prod[WIDTH-1]}};
            err_d    = 1'b0;
`ifdef ALU_MC_DIV_EN
            div_zero_d = 1'b0;
`endif
          end
        end
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // Registered handshake outputs follow the next state, so in_ready stays
    // low during reset and rises on the first edge after it is released.
    in_ready_d  = (state_d == IDLE);
    out_valid_d = (state_d == DONE);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      result_q    <= '0;
      ovf_q       <= 1'b0;
      err_q       <= 1'b0;
      cnt_q       <= '0;
      acc_q       <= '0;
      mcand_q     <= '0;
      mplier_q    <= '0;
      neg_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      result_q    <= result_d;
      ovf_q       <= ovf_d;
      err_q       <= err_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      mcand_q     <= mcand_d;
      mplier_q    <= mplier_d;
      neg_q       <= neg_d;
    end
  end

`ifdef ALU_MC_DIV_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_zero_q <= 1'b0;
      is_div_q   <= 1'b0;
      is_mod_q   <= 1'b0;
      ovf_pend_q <= 1'b0;
    end else begin
      div_zero_q <= div_zero_d;
      is_div_q   <= is_div_d;
      is_mod_q   <= is_mod_d;
      ovf_pend_q <= ovf_pend_d;
    end
  end
  assign div_zero = div_zero_q;
`else
  assign div_zero = 1'b0;
`endif

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign result    = result_q;
  assign overflow  = ovf_q;
  assign error     = err_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_alu_mc.sv
// -----------------------------------------------------------------------------
// tb_alu_mc -- directed bench for alu_mc at WIDTH=32. The driver pushes the
// hand-computed expectation for every accepted request; an independent monitor
// checks the result port whenever out_valid is high. Latency counts the
// accepting edge as edge 1.
// -----------------------------------------------------------------------------
module tb_alu_mc;

  localparam int W = 32;

  localparam logic [4:0] OP_NOP  = 5'd0;
  localparam logic [4:0] OP_NOT  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_NAND = 5'd5;
  localparam logic [4:0] OP_NOR  = 5'd6;
  localparam logic [4:0] OP_NXOR = 5'd7;
  localparam logic [4:0] OP_LSH  = 5'd8;
  localparam logic [4:0] OP_RSH  = 5'd9;
  localparam logic [4:0] OP_ALSH = 5'd10;
  localparam logic [4:0] OP_ARSH = 5'd11;
  localparam logic [4:0] OP_ROTL = 5'd12;
  localparam logic [4:0] OP_ROTR = 5'd13;
  localparam logic [4:0] OP_INC  = 5'd14;
  localparam logic [4:0] OP_DEC  = 5'd15;
  localparam logic [4:0] OP_ADD  = 5'd16;
  localparam logic [4:0] OP_SUB  = 5'd17;
  localparam logic [4:0] OP_MUL  = 5'd18;
  localparam logic [4:0] OP_DIV  = 5'd19;
  localparam logic [4:0] OP_MOD  = 5'd20;

  // ---------------------------------------------------------------------------
  // Clock / reset / DUT
  // ---------------------------------------------------------------------------
  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [4:0]   opcode = '0;
  logic [W-1:0] data_a = '0;
  logic [W-1:0] data_b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         overflow, error, div_zero;
  logic [1:0]   dbg_state;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  alu_mc #(.WIDTH(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .data_a    (data_a),
    .data_b    (data_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .result    (result),
    .overflow  (overflow),
    .error     (error),
    .div_zero  (div_zero),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [W-1:0] res;
    logic         ovf;
    logic         err;
    logic         dz;
    logic [7:0]   lat;
    logic [31:0]  acc_cyc;
  } exp_t;

  exp_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    failures = 0;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitor
  // ---------------------------------------------------------------------------
  logic ov_prev = 1'b0;
  always @(negedge clk) begin
    exp_t  cur;
    string nm;
    if (reset) begin
      ov_prev = 1'b0;
    end else begin
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_out_valid: actual=1 expected=0");
        end else begin
          cur = exp_q[0];
          nm  = name_q[0];
          if (!ov_prev)
            check({nm, "_latency"}, 64'(cyc - int'(cur.acc_cyc) + 1),
                  64'(cur.lat));
          check({nm, "_result"},   64'(result),   64'(cur.res));
          check({nm, "_overflow"}, 64'(overflow), 64'(cur.ovf));
          check({nm, "_error"},    64'(error),    64'(cur.err));
          check({nm, "_div_zero"}, 64'(div_zero), 64'(cur.dz));
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(name_q.pop_front());
          end
        end
      end
      ov_prev = out_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic issue(input string name, input logic [4:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [W-1:0] res, input logic ovf,
                       input logic err, input logic dz, input int lat);
    int   guard;
    exp_t e;
    guard = 0;
    @(negedge clk);
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) begin
      checks++;
      failures++;
      $display("FAIL %s_accept_timeout: in_ready=0 expected=1", name);
    end else begin
      opcode   = op;
      data_a   = a;
      data_b   = b;
      in_valid = 1'b1;
      @(posedge clk);
      #1;
      e.res     = res;
      e.ovf     = ovf;
      e.err     = err;
      e.dz      = dz;
      e.lat     = 8'(lat);
      e.acc_cyc = 32'(cyc);
      exp_q.push_back(e);
      name_q.push_back(name);
      in_valid = 1'b0;
      // Scramble inputs: the captured request must be unaffected.
      data_a   = $urandom;
      data_b   = $urandom;
      opcode   = 5'($urandom_range(0, 31));
    end
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    while (exp_q.size() != 0 && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout: pending=%0d expected=0", exp_q.size());
      exp_q.delete();
      name_q.delete();
    end
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    // Reset state
    #3;
    check("rst_in_ready",  64'(in_ready),  64'd0);
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result",    64'(result),    64'd0);
    check("rst_flags",     64'({overflow, error, div_zero}), 64'd0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("rst_in_ready_before_edge", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1;
    check("rst_in_ready_first_edge", 64'(in_ready), 64'd1);

    // Arithmetic with wrap and signed overflow
    issue("add_ovf", OP_ADD, 32'h7FFFFFFF, 32'h00000001, 32'h80000000, 1, 0, 0, 1);
    issue("add_mix", OP_ADD, 32'h00000005, 32'hFFFFFFFD, 32'h00000002, 0, 0, 0, 1);
    issue("sub_ovf", OP_SUB, 32'h80000000, 32'h00000001, 32'h7FFFFFFF, 1, 0, 0, 1);
    issue("sub_neg", OP_SUB, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 0, 0, 0, 1);
    issue("inc_ovf", OP_INC, 32'h7FFFFFFF, 32'h00000000, 32'h80000000, 1, 0, 0, 1);
    issue("dec_ovf", OP_DEC, 32'h80000000, 32'h00000000, 32'h7FFFFFFF, 1, 0, 0, 1);

    // Logic ops
    issue("not",  OP_NOT,  32'hF0F0F0F0, 32'h00000000, 32'h0F0F0F0F, 0, 0, 0, 1);
    issue("and",  OP_AND,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 0, 0, 0, 1);
    issue("or",   OP_OR,   32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 0, 0, 0, 1);
    issue("xor",  OP_XOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0, 0, 0, 0, 1);
    issue("nand", OP_NAND, 32'hF0F0F0F0, 32'hFF00FF00, 32'h0FFF0FFF, 0, 0, 0, 1);
    issue("nor",  OP_NOR,  32'hF0F0F0F0, 32'hFF00FF00, 32'h000F000F, 0, 0, 0, 1);
    issue("nxor", OP_NXOR, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF00FF00F, 0, 0, 0, 1);

    // Shifts and rotates, including out-of-range amounts
    issue("arsh_40", OP_ARSH, 32'h80000000, 32'd40, 32'hFFFFFFFF, 0, 0, 0, 1);
    issue("lsh_32",  OP_LSH,  32'h00000001, 32'd32, 32'h00000000, 0, 0, 0, 1);
    issue("rotl_33", OP_ROTL, 32'h80000001, 32'd33, 32'h00000003, 0, 0, 0, 1);
    issue("rsh_4",   OP_RSH,  32'h80000000, 32'd4,  32'h08000000, 0, 0, 0, 1);
    issue("arsh_4",  OP_ARSH, 32'h80000000, 32'd4,  32'hF8000000, 0, 0, 0, 1);
    issue("alsh_4",  OP_ALSH, 32'h00000003, 32'd4,  32'h00000030, 0, 0, 0, 1);
    issue("rsh_big", OP_RSH,  32'hFFFFFFFF, 32'h00010000, 32'h00000000, 0, 0, 0, 1);
    issue("rotr_1",  OP_ROTR, 32'h00000003, 32'd1,  32'h80000001, 0, 0, 0, 1);

    // NOP keeps the previous result (rotr_1), unknown opcode reports error
    issue("nop",     OP_NOP,  32'h12345678, 32'h9ABCDEF0, 32'h80000001, 0, 0, 0, 1);
    issue("unknown", 5'd31,   32'h12345678, 32'h9ABCDEF0, 32'h00000000, 0, 1, 0, 1);

    // Multiplier
    issue("mul_ovf",   OP_MUL, 32'h00010000, 32'h00010000, 32'h00000000, 1, 0, 0, 33);
    issue("mul_neg",   OP_MUL, 32'hFFFFFFFD, 32'h00000007, 32'hFFFFFFEB, 0, 0, 0, 33);
    issue("mul_ovf2",  OP_MUL, 32'h7FFFFFFF, 32'h00000002, 32'hFFFFFFFE, 1, 0, 0, 33);
    issue("mul_negneg",OP_MUL, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'h00000006, 0, 0, 0, 33);

`ifdef ALU_MC_DIV_EN
    issue("div_neg",   OP_DIV, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, 0, 0, 0, 33);
    issue("mod_neg",   OP_MOD, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 0, 0, 0, 33);
    issue("div_zero",  OP_DIV, 32'h00000005, 32'h00000000, 32'hFFFFFFFF, 0, 1, 1, 1);
    issue("mod_zero",  OP_MOD, 32'h00000005, 32'h00000000, 32'h00000005, 0, 1, 1, 1);
    issue("div_min",   OP_DIV, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 0, 0, 33);
    issue("mod_min",   OP_MOD, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 0, 0, 0, 33);
    issue("div_pos",   OP_DIV, 32'd100,      32'd7,        32'd14,       0, 0, 0, 33);
    issue("mod_neg2",  OP_MOD, 32'hFFFFFF9C, 32'd7,        32'hFFFFFFFE, 0, 0, 0, 33);
`else
    issue("div_off",   OP_DIV, 32'h00000005, 32'h00000002, 32'h00000000, 0, 1, 0, 1);
    issue("mod_off",   OP_MOD, 32'h00000005, 32'h00000002, 32'h00000000, 0, 1, 0, 1);
`endif
    drain();

    // Backpressure: hold a finished XOR for 5 cycles while a new request waits
    out_ready = 1'b0;
    issue("xor_hold", OP_XOR, 32'hAAAA5555, 32'h0000FFFF, 32'hAAAAAAAA, 0, 0, 0, 1);
    for (int i = 0; i < 5; i++) begin
      check("hold_in_ready", 64'(in_ready), 64'd0);
      in_valid = 1'b1;
      opcode   = OP_ADD;
      data_a   = 32'h00000001;
      data_b   = 32'h00000001;
      @(posedge clk);
      #1;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("release_out_valid", 64'(out_valid), 64'd0);
    check("release_in_ready",  64'(in_ready),  64'd1);
    drain();

    // Reset in the middle of a MUL abandons it
    issue("mul_abort", OP_MUL, 32'h00000003, 32'h00000005, 32'h0000000F, 0, 0, 0, 33);
    repeat (10) @(posedge clk);
    #2;
    reset = 1'b1;
    #1;
    check("abort_in_ready",  64'(in_ready),  64'd0);
    check("abort_out_valid", 64'(out_valid), 64'd0);
    check("abort_result",    64'(result),    64'd0);
    check("abort_flags",     64'({overflow, error, div_zero}), 64'd0);
    exp_q.delete();
    name_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0;
    check("abort_out_valid_low", 64'(out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("abort_in_ready_first_edge", 64'(in_ready), 64'd1);
    check("abort_no_out_valid",        64'(out_valid), 64'd0);
    issue("add_after_rst", OP_ADD, 32'h00000002, 32'h00000003, 32'h00000005, 0, 0, 0, 1);
    drain();
    // Idle window: the monitor reports any stray out_valid here.
    repeat (40) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #400000;
    failures++;
    $display("FAIL watchdog: time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

endmodule
